// File: rtl/spi_secondary_pkg.sv
// rtl/spi_secondary_pkg.sv - shared types for the SPI secondary
package spi_secondary_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_secondary_mode_if.sv
// rtl/spi_secondary_mode_if.sv - SPI pins plus rx/tx word handshake of the SPI secondary
interface spi_secondary_mode_if #(
    parameter int WordBits = 8
);
    logic                sck;
    logic                in_bit;
    logic                out_bit;
    logic                cs;
    logic                cpol;
    logic                cpha;
    logic [WordBits-1:0] rx_data;
    logic                rx_valid;
    logic [WordBits-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                underrun;

    modport slave (
        input  sck, in_bit, cs, cpol, cpha, tx_data, tx_valid,
        output out_bit, rx_data, rx_valid, tx_ready, underrun
    );

    modport master (
        output sck, in_bit, cs, cpol, cpha, tx_data, tx_valid,
        input  out_bit, rx_data, rx_valid, tx_ready, underrun
    );
endinterface

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop synchroniser with registered rise/fall pulses
module spi_edge_sync #(
    parameter int   Stages   = 2,
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [Stages-1:0] chain;
    logic              prev;

    // q is the delayed level, so it stays aligned with the edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {Stages{ResetVal}};
            prev  <= ResetVal;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[Stages-2:0], d};
            prev  <= chain[Stages-1];
            rise  <= chain[Stages-1] & ~prev;
            fall  <= ~chain[Stages-1] & prev;
        end
    end

    assign q = prev;
endmodule

// File: rtl/spi_secondary_mode.sv
// rtl/spi_secondary_mode.sv - SPI secondary; SPI_SECONDARY_MODE_EN enables CPOL/CPHA, otherwise mode 0 only
module spi_secondary_mode
    import spi_secondary_pkg::*;
#(
    parameter int                  WordBits   = 8,
    parameter int                  SyncStages = 2,
    parameter logic [WordBits-1:0] FillWord   = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_secondary_mode_if.slave bus
);
    localparam int              CntW      = $clog2(WordBits);
    localparam logic [0:0]      ST_IDLE   = IDLE;
    localparam logic [0:0]      ST_ACTIVE = ACTIVE;
    localparam logic [CntW-1:0] LastBit   = CntW'(WordBits - 1);

    logic                  sck_s, sck_rise, sck_fall;
    logic                  cs_s, cs_rise, cs_fall;
    logic [SyncStages-1:0] in_sync;
    logic                  in_s;
    logic [0:0]            state;
    spi_mode_t             mode;
    logic [WordBits-1:0]   rx_shift, rx_next, rx_data_q;
    logic [WordBits-1:0]   tx_shift, tx_word, hold;
    logic [CntW-1:0]       rx_cnt, tx_cnt;
    logic                  rx_valid_q, underrun_q, out_bit_q, full;
    logic                  active, go_active, lead, trail;
    logic                  sample_edge, shift_edge, tx_event, load;
    logic                  unused_sync;

    spi_edge_sync #(.Stages(SyncStages), .ResetVal(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_edge_sync #(.Stages(SyncStages), .ResetVal(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign unused_sync = sck_s ^ cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_sync <= '0;
        else        in_sync <= {in_sync[SyncStages-2:0], bus.in_bit};
    end
    assign in_s = in_sync[SyncStages-1];

`ifdef SPI_SECONDARY_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= '0;
        end else if (state == ST_IDLE) begin
            mode.cpol <= bus.cpol;
            mode.cpha <= bus.cpha;
        end
    end
`else
    logic unused_mode;
    assign mode        = '0;
    assign unused_mode = bus.cpol ^ bus.cpha;
`endif

    // a cs deassert wins over any sck edge seen in the same cycle
    assign active      = (state == ST_ACTIVE) && !cs_rise;
    assign go_active   = (state == ST_IDLE) && cs_fall;
    assign lead        = mode.cpol ? sck_fall : sck_rise;
    assign trail       = mode.cpol ? sck_rise : sck_fall;
    assign sample_edge = active && (mode.cpha ? trail : lead);
    assign shift_edge  = active && (mode.cpha ? lead : trail);
    assign tx_event    = shift_edge || (go_active && !mode.cpha);
    assign load        = tx_event && (tx_cnt == '0);
    assign tx_word     = load ? (full ? hold : FillWord) : tx_shift;
    assign rx_next     = {rx_shift[WordBits-2:0], in_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rx_shift   <= '0;
            rx_cnt     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            hold       <= '0;
            full       <= 1'b0;
            out_bit_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            if (go_active)
                state <= ST_ACTIVE;
            else if (state == ST_ACTIVE && cs_rise)
                state <= ST_IDLE;

            if (sample_edge) begin
                rx_shift <= rx_next;
                if (rx_cnt == LastBit) begin
                    rx_cnt     <= '0;
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (!active) begin
                rx_cnt <= '0;
            end

            if (tx_event) begin
                out_bit_q <= tx_word[WordBits-1];
                tx_shift  <= {tx_word[WordBits-2:0], 1'b0};
                tx_cnt    <= (tx_cnt == LastBit) ? '0 : tx_cnt + 1'b1;
            end else if (!active) begin
                tx_cnt <= '0;
            end

            if (load && !full)
                underrun_q <= 1'b1;

            // writes are only accepted while empty, so they never race a load of valid data
            if (bus.tx_valid && !full) begin
                hold <= bus.tx_data;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    assign bus.out_bit  = out_bit_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_ready = !full;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_spi_secondary_mode.sv
// tb/tb_spi_secondary_mode.sv - randomized bench for spi_secondary_mode against a word-level model
module tb_spi_secondary_mode;
    localparam int         W     = 8;
    localparam int         H     = 6;
    localparam int         SETUP = 8;
    localparam int         GAP   = 10;
    localparam logic [7:0] FILL  = 8'h00;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   und_cnt;
    logic [7:0]  rx_q[$];
    logic [7:0]  model_q[$];
    logic [15:0] dummy;

    spi_secondary_mode_if #(.WordBits(W)) bus ();

    spi_secondary_mode #(
        .WordBits(W), .SyncStages(2), .FillWord(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (rst_n && bus.underrun === 1'b1) und_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] w);
        @(negedge clk);
        check("pre_tx_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        model_q.push_back(w);
    endtask

    task automatic mid_write(input logic [7:0] w);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.rx_valid !== 1'b1 && t < 4000);
        check("mid_wait_rx_valid", 32'(bus.rx_valid), 32'd1);
        check("mid_tx_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // SPI main: MSB first, samples out_bit just before its own sample edge
    task automatic spi_xfer(input logic [1:0] pm, input int n, input logic [15:0] mosi,
                            output logic [15:0] miso);
        logic cpol, cpha;
`ifdef SPI_SECONDARY_MODE_EN
        {cpol, cpha} = pm;
`else
        {cpol, cpha} = 2'b00;
`endif
        miso = '0;
        @(negedge clk);
        bus.cpol = pm[1];
        bus.cpha = pm[0];
        bus.sck  = cpol;
        repeat (GAP) @(negedge clk);
        bus.cs = 1'b0;
        if (!cpha) bus.in_bit = mosi[n-1];
        repeat (SETUP) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                miso = {miso[14:0], bus.out_bit};
                bus.sck = ~cpol;
                repeat (H) @(negedge clk);
                bus.sck    = cpol;
                bus.in_bit = (i + 1 < n) ? mosi[n-2-i] : 1'b0;
                repeat (H) @(negedge clk);
            end else begin
                bus.sck    = ~cpol;
                bus.in_bit = mosi[n-1-i];
                repeat (H) @(negedge clk);
                miso = {miso[14:0], bus.out_bit};
                bus.sck = cpol;
                repeat (H) @(negedge clk);
            end
        end
        bus.cs = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [1:0] pm, input int n, input logic [15:0] mosi_in,
                       input bit pre, input logic [7:0] pre_w, input bit mid, input logic [7:0] mid_w);
        logic [15:0] mosi, miso, exp_miso;
        logic [31:0] mask;
        logic [7:0]  loaded[$];
        logic [7:0]  w;
        int          e, nloads, exp_und, rx0, und0;
        bit          cpha_eff;
        mask = (32'h1 << n) - 32'h1;
        mosi = mosi_in & mask[15:0];
`ifdef SPI_SECONDARY_MODE_EN
        cpha_eff = pm[0];
`else
        cpha_eff = 1'b0;
`endif
        if (pre) tx_write(pre_w);
        // one tx event per shift edge, plus the select itself when cpha=0; every W-th event loads a word
        e       = n + (cpha_eff ? 0 : 1);
        nloads  = (e + W - 1) / W;
        exp_und = 0;
        for (int l = 0; l < nloads; l++) begin
            if (l == 1 && mid) model_q.push_back(mid_w);
            if (model_q.size() > 0) begin
                loaded.push_back(model_q.pop_front());
            end else begin
                loaded.push_back(FILL);
                exp_und++;
            end
        end
        exp_miso = '0;
        for (int j = 0; j < n; j++) begin
            w        = loaded[j / W];
            exp_miso = {exp_miso[14:0], w[W-1-(j%W)]};
        end
        rx0  = rx_q.size();
        und0 = und_cnt;
        fork
            spi_xfer(pm, n, mosi, miso);
            if (mid) mid_write(mid_w);
        join
        check({tag, "_miso"}, 32'(miso), 32'(exp_miso));
        check({tag, "_rx_count"}, 32'(rx_q.size() - rx0), 32'(n / W));
        for (int k = 0; k < n / W && rx0 + k < rx_q.size(); k++)
            check({tag, "_rx_data"}, 32'(rx_q[rx0+k]), 32'(8'(mosi >> (n - (k + 1) * W))));
        check({tag, "_underrun"}, 32'(und_cnt - und0), 32'(exp_und));
        check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'(model_q.size() == 0));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        und_cnt      = 0;
        rst_n        = 1'b0;
        bus.sck      = 1'b0;
        bus.cs       = 1'b1;
        bus.in_bit   = 1'b0;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_bit", 32'(bus.out_bit), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_underrun", 32'(bus.underrun), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int m = 0; m < 4; m++)
            run($sformatf("mode%0d", m), 2'(m), 8, 16'h003C, 1'b1, 8'hA5, 1'b0, 8'h00);
        run("b2b_m0", 2'b00, 16, 16'h3CC3, 1'b1, 8'hA5, 1'b1, 8'h5A);
        run("b2b_m3", 2'b11, 16, 16'h96E1, 1'b1, 8'hA5, 1'b1, 8'h5A);
        run("fill_m0", 2'b00, 16, 16'h1234, 1'b1, 8'hA5, 1'b0, 8'h00);
        run("fill_m1", 2'b01, 16, 16'hBEEF, 1'b1, 8'hA5, 1'b0, 8'h00);
        run("abort", 2'b00, 5, 16'h0015, 1'b1, 8'h81, 1'b0, 8'h00);
        run("after_abort", 2'b00, 8, 16'h00E7, 1'b1, 8'h66, 1'b0, 8'h00);

        for (int it = 0; it < 16; it++) begin
            int n;
            bit m;
            n = $urandom_range(5, 16);
            m = (n > W) && ($urandom_range(0, 1) == 1);
            run($sformatf("rnd%0d", it), 2'($urandom_range(0, 3)), n, 16'($urandom),
                $urandom_range(0, 1) == 1, 8'($urandom), m, 8'($urandom));
        end

        tx_write(8'hC3);
        fork
            spi_xfer(2'b00, 16, 16'h1234, dummy);
            begin
                repeat (GAP + SETUP + 40) @(negedge clk);
                tx_write(8'h77);
                check("rst_pre_tx_ready", 32'(bus.tx_ready), 32'd0);
                #3 rst_n = 1'b0;
                #1;
                check("rst_out_bit", 32'(bus.out_bit), 32'd0);
                check("rst_rx_data", 32'(bus.rx_data), 32'd0);
                check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
                check("rst_underrun", 32'(bus.underrun), 32'd0);
            end
        join
        model_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run("post_reset", 2'b00, 8, 16'h00D2, 1'b1, 8'h3E, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
